// File: rtl/csr_hpm_counters.sv
`default_nettype none
// ============================================================================
// Module   : csr_hpm_counters
// Purpose  : Machine-mode hardware performance-monitor bank. Implements
//            mhpmcounter3.. (low half 0xB00+K, high half 0xB80+K), their
//            event selectors mhpmevent3.. (0x320+K) and mcountinhibit (0x320)
//            on the shared CSR read/write bus. Each counter increments on
//            its selected single-cycle event pulse and wraps at
//            COUNTER_WIDTH bits.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            priv_level         - privilege of the issuing instruction
//            csr_raddr/rdata/hit- combinational read port and ownership flag
//            csr_wen/waddr/wdata- write port (single-cycle)
//            event_pulse        - event inputs, bit e-1 is event number e
//            freeze             - global count hold (debug halt)
//            ovf_vec, ovf_irq   - per-counter overflow flags and their OR
// Config   : HPM_OVERFLOW_IRQ_EN - when defined, builds the sticky OF flags
//            and the overflow interrupt; otherwise counters wrap silently.
// Revision : 1.0 - initial release
// ============================================================================
module csr_hpm_counters #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 40,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              priv_level,
  input  logic [11:0]             csr_raddr,
  output logic [31:0]             csr_rdata,
  output logic                    csr_hit,
  input  logic                    csr_wen,
  input  logic [11:0]             csr_waddr,
  input  logic [31:0]             csr_wdata,
  input  logic [NUM_EVENTS-1:0]   event_pulse,
  input  logic                    freeze,
  output logic [NUM_COUNTERS-1:0] ovf_vec,
  output logic                    ovf_irq
);

  localparam int          HI_W           = COUNTER_WIDTH - 32;
  localparam logic [11:0] c_cnt_lo_base  = 12'hB00;
  localparam logic [11:0] c_cnt_hi_base  = 12'hB80;
  localparam logic [11:0] c_evt_base     = 12'h320;  // also mcountinhibit

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [COUNTER_WIDTH-1:0] r_cnt [NUM_COUNTERS];
  logic [7:0]               r_sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  r_inh;

  // OF view used by the read mux; constant zero when OF is not built
  logic [NUM_COUNTERS-1:0]  w_of;
  logic [NUM_COUNTERS-1:0]  w_of_nxt;

  // --------------------------------------------------------------------------
  // Write decode and legalisation
  // --------------------------------------------------------------------------
  logic                     w_wperm;
  logic [7:0]               w_sel_legal;
  logic [NUM_COUNTERS-1:0]  w_wr_lo;
  logic [NUM_COUNTERS-1:0]  w_wr_hi;
  logic [NUM_COUNTERS-1:0]  w_wr_ev;
  logic                     w_wr_inh;

  // Address bits [9:8] encode the minimum privilege for the CSR
  assign w_wperm     = csr_wen && (priv_level >= csr_waddr[9:8]);
  // Out-of-range event numbers are stored as "no event"
  assign w_sel_legal = (csr_wdata[7:0] > 8'(NUM_EVENTS)) ? 8'd0 : csr_wdata[7:0];
  assign w_wr_inh    = w_wperm && (csr_waddr == c_evt_base);

  always_comb begin
    w_wr_lo = '0;
    w_wr_hi = '0;
    w_wr_ev = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_wr_lo[i] = w_wperm && (csr_waddr == c_cnt_lo_base + 12'(i + 3));
      w_wr_hi[i] = w_wperm && (csr_waddr == c_cnt_hi_base + 12'(i + 3));
      w_wr_ev[i] = w_wperm && (csr_waddr == c_evt_base    + 12'(i + 3));
    end
  end

  // --------------------------------------------------------------------------
  // Increment enables: selected event present, not inhibited, not frozen,
  // and no write to either half of this counter (the write wins)
  // --------------------------------------------------------------------------
  logic [NUM_COUNTERS-1:0] w_evt;
  logic [NUM_COUNTERS-1:0] w_inc;

  always_comb begin
    w_evt = '0;
    w_inc = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      for (int e = 1; e <= NUM_EVENTS; e++) begin
        if (r_sel[i] == 8'(e)) begin
          w_evt[i] = event_pulse[e-1];
        end
      end
      w_inc[i] = w_evt[i] && !r_inh[i] && !freeze && !w_wr_lo[i] && !w_wr_hi[i];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state for counters, selectors and inhibit bits
  // --------------------------------------------------------------------------
  logic [COUNTER_WIDTH-1:0] w_cnt_nxt [NUM_COUNTERS];
  logic [7:0]               w_sel_nxt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  w_inh_nxt;

  always_comb begin
    w_inh_nxt = r_inh;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_sel_nxt[i] = r_sel[i];
      if (w_wr_lo[i]) begin
        w_cnt_nxt[i][31:0] = csr_wdata;
      end
      if (w_wr_hi[i]) begin
        w_cnt_nxt[i][COUNTER_WIDTH-1:32] = csr_wdata[HI_W-1:0];
      end
      if (w_inc[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + COUNTER_WIDTH'(1);
      end
      if (w_wr_ev[i]) begin
        w_sel_nxt[i] = w_sel_legal;
      end
      if (w_wr_inh) begin
        w_inh_nxt[i] = csr_wdata[i + 3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= '0;
      end
      r_inh <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_sel[i] <= w_sel_nxt[i];
      end
      r_inh <= w_inh_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Overflow flags
  // --------------------------------------------------------------------------
`ifdef HPM_OVERFLOW_IRQ_EN
  logic [NUM_COUNTERS-1:0] r_of;
  logic                    r_irq;

  // A wrap on the same edge as a clearing write keeps OF set
  always_comb begin
    w_of_nxt = r_of;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (w_wr_ev[i]) begin
        w_of_nxt[i] = csr_wdata[31];
      end
      if (w_inc[i] && (&r_cnt[i])) begin
        w_of_nxt[i] = 1'b1;
      end
    end
  end

  // The interrupt is its own flop so no combinational path reaches ovf_irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_of  <= '0;
      r_irq <= 1'b0;
    end else begin
      r_of  <= w_of_nxt;
      r_irq <= |w_of_nxt;
    end
  end

  assign w_of    = r_of;
  assign ovf_vec = r_of;
  assign ovf_irq = r_irq;
`else
  assign w_of     = '0;
  assign w_of_nxt = '0;
  assign ovf_vec  = '0;
  assign ovf_irq  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Bypass image: the read view of csr_waddr after this cycle's write.
  // Unimplemented K and foreign addresses give 0.
  // --------------------------------------------------------------------------
  logic [31:0] w_wimg;

  always_comb begin
    w_wimg = '0;
    if (csr_waddr == c_evt_base) begin
      w_wimg[3 +: NUM_COUNTERS] = csr_wdata[3 +: NUM_COUNTERS];
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_waddr == c_cnt_lo_base + 12'(i + 3)) begin
        w_wimg = csr_wdata;
      end
      if (csr_waddr == c_cnt_hi_base + 12'(i + 3)) begin
        w_wimg[HI_W-1:0] = csr_wdata[HI_W-1:0];
      end
      if (csr_waddr == c_evt_base + 12'(i + 3)) begin
        w_wimg = {w_of_nxt[i], 23'd0, w_sel_legal};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  always_comb begin
    csr_hit = ((csr_raddr[11:5] == c_cnt_lo_base[11:5]) && (csr_raddr[4:0] >= 5'd3)) ||
              ((csr_raddr[11:5] == c_cnt_hi_base[11:5]) && (csr_raddr[4:0] >= 5'd3)) ||
              ((csr_raddr[11:5] == c_evt_base[11:5])    &&
               ((csr_raddr[4:0] >= 5'd3) || (csr_raddr[4:0] == 5'd0)));

    csr_rdata = '0;
    if (csr_raddr == c_evt_base) begin
      csr_rdata[3 +: NUM_COUNTERS] = r_inh;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_raddr == c_cnt_lo_base + 12'(i + 3)) begin
        csr_rdata = r_cnt[i][31:0];
      end
      if (csr_raddr == c_cnt_hi_base + 12'(i + 3)) begin
        csr_rdata[HI_W-1:0] = r_cnt[i][COUNTER_WIDTH-1:32];
      end
      if (csr_raddr == c_evt_base + 12'(i + 3)) begin
        csr_rdata = {w_of[i], 23'd0, r_sel[i]};
      end
    end
    if (w_wperm && (csr_waddr == csr_raddr)) begin
      csr_rdata = w_wimg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_hpm_counters.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_hpm_counters
// Purpose  : Self-checking bench for csr_hpm_counters with default
//            parameters. A behavioural state model is stepped on every clock
//            edge and compared against the DUT on every falling edge;
//            directed literal expectations pin both DUT and model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_hpm_counters;

  localparam int NC = 4;
  localparam int W  = 40;
  localparam int NE = 8;
`ifdef HPM_OVERFLOW_IRQ_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  localparam logic [63:0] CMASK = (64'd1 << W) - 64'd1;

  logic          clk;
  logic          rst_n;
  logic [1:0]    priv_level;
  logic [11:0]   csr_raddr;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic          csr_wen;
  logic [11:0]   csr_waddr;
  logic [31:0]   csr_wdata;
  logic [NE-1:0] event_pulse;
  logic          freeze;
  logic [NC-1:0] ovf_vec;
  logic          ovf_irq;

  int checks   = 0;
  int failures = 0;

  csr_hpm_counters #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(W),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .priv_level (priv_level),
    .csr_raddr  (csr_raddr),
    .csr_rdata  (csr_rdata),
    .csr_hit    (csr_hit),
    .csr_wen    (csr_wen),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .event_pulse(event_pulse),
    .freeze     (freeze),
    .ovf_vec    (ovf_vec),
    .ovf_irq    (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model: full architectural state as plain numbers
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [NC-1:0][63:0] cnt;
    logic [NC-1:0][7:0]  sel;
    logic [NC-1:0]       inh;
    logic [NC-1:0]       of;
  } st_t;

  st_t m = '0;

  function automatic st_t step(st_t s);
    st_t  n;
    logic perm;
    logic written;
    logic wrap;
    int   ev;
    n    = s;
    perm = csr_wen && (priv_level >= csr_waddr[9:8]);
    for (int i = 0; i < NC; i++) begin
      written = perm && (csr_waddr == 12'hB00 + 12'(i + 3) || csr_waddr == 12'hB80 + 12'(i + 3));
      wrap    = 1'b0;
      if (perm && csr_waddr == 12'hB00 + 12'(i + 3))
        n.cnt[i] = (s.cnt[i] & ~64'hFFFF_FFFF) | 64'(csr_wdata);
      if (perm && csr_waddr == 12'hB80 + 12'(i + 3))
        n.cnt[i] = (s.cnt[i] & 64'hFFFF_FFFF) | ((64'(csr_wdata) << 32) & CMASK);
      ev = int'(s.sel[i]);
      if (!written && ev != 0 && event_pulse[ev-1] && !s.inh[i] && !freeze) begin
        n.cnt[i] = (s.cnt[i] + 64'd1) & CMASK;
        wrap     = (n.cnt[i] == 64'd0);
      end
      if (perm && csr_waddr == 12'h320 + 12'(i + 3)) begin
        n.sel[i] = (int'(csr_wdata[7:0]) > NE) ? 8'd0 : csr_wdata[7:0];
        if (OVF) n.of[i] = csr_wdata[31];
      end
      if (OVF && wrap) n.of[i] = 1'b1;
      if (perm && csr_waddr == 12'h320) n.inh[i] = csr_wdata[i + 3];
    end
    return n;
  endfunction

  // Returns {hit, data} for a read of address a from state s
  function automatic logic [32:0] rd(st_t s, logic [11:0] a);
    logic [31:0] d;
    logic        h;
    int          k;
    d = '0;
    h = 1'b0;
    k = int'(a[4:0]) - 3;
    if (a >= 12'hB03 && a <= 12'hB1F) begin
      h = 1'b1;
      if (k < NC) d = s.cnt[k][31:0];
    end else if (a >= 12'hB83 && a <= 12'hB9F) begin
      h = 1'b1;
      if (k < NC) d = 32'(s.cnt[k] >> 32);
    end else if (a >= 12'h323 && a <= 12'h33F) begin
      h = 1'b1;
      if (k < NC) d = {s.of[k], 23'd0, s.sel[k]};
    end else if (a == 12'h320) begin
      h = 1'b1;
      for (int i = 0; i < NC; i++) d[i + 3] = s.inh[i];
    end
    return {h, d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m = '0;
    else        m = step(m);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [32:0] e;
    if (csr_wen && (priv_level >= csr_waddr[9:8]) && (csr_waddr == csr_raddr))
      e = rd(step(m), csr_raddr);
    else
      e = rd(m, csr_raddr);
    chk("cyc_hit",   64'(csr_hit),   64'(e[32]));
    chk("cyc_rdata", 64'(csr_rdata), 64'(e[31:0]));
    chk("cyc_ovf_vec", 64'(ovf_vec), 64'(m.of));
    chk("cyc_ovf_irq", 64'(ovf_irq), 64'(|m.of));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wen   = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
    csr_wen   = 1'b0;
  endtask

  task automatic pulse(input logic [NE-1:0] v, input int n);
    event_pulse = v;
    repeat (n) tick();
    event_pulse = '0;
  endtask

  // Idle cycle, then read a and compare DUT and model with a literal
  task automatic lit(input string name, input logic [11:0] a, input logic hit, input logic [31:0] d);
    logic [32:0] e;
    tick();
    csr_raddr = a;
    #1;
    e = rd(m, a);
    chk({name, "_hit"},   64'(csr_hit), 64'(hit));
    chk({name, "_dut"},   64'(csr_rdata), 64'(d));
    chk({name, "_model"}, 64'(e[31:0]), 64'(d));
  endtask

  localparam logic [NE-1:0] PAT [7] = '{8'h80, 8'h01, 8'h81, 8'h02, 8'hFF, 8'h00, 8'h80};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    priv_level  = 2'd3;
    csr_raddr   = 12'hB03;
    csr_wen     = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    event_pulse = '0;
    freeze      = 1'b0;

    // Reset state
    lit("rst_cnt", 12'hB03, 1'b1, 32'h0);
    lit("rst_evt", 12'h323, 1'b1, 32'h0);
    chk("rst_ovf_irq", 64'(ovf_irq), 64'd0);
    tick();
    rst_n = 1'b1;

    // Select event 2 and count five pulses
    wr(12'h323, 32'd2);
    pulse(8'h02, 5);
    lit("sel_lo", 12'hB03, 1'b1, 32'd5);
    lit("sel_hi", 12'hB83, 1'b1, 32'd0);

    // Inhibit, then freeze
    wr(12'h320, 32'h8);
    lit("inh_rd", 12'h320, 1'b1, 32'h8);
    pulse(8'h02, 4);
    lit("inh_cnt", 12'hB03, 1'b1, 32'd5);
    wr(12'h320, 32'h0);
    freeze = 1'b1;
    pulse(8'h02, 3);
    freeze = 1'b0;
    lit("frz_cnt", 12'hB03, 1'b1, 32'd5);

    // Wrap at 40 bits
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    lit("pre_hi", 12'hB83, 1'b1, 32'hFF);
    lit("pre_lo", 12'hB03, 1'b1, 32'hFFFF_FFFF);
    pulse(8'h02, 1);
    chk("wrap_ovf_vec", 64'(ovf_vec), OVF ? 64'd1 : 64'd0);
    chk("wrap_ovf_irq", 64'(ovf_irq), OVF ? 64'd1 : 64'd0);
    lit("wrap_lo", 12'hB03, 1'b1, 32'd0);
    lit("wrap_hi", 12'hB83, 1'b1, 32'd0);
    lit("wrap_evt", 12'h323, 1'b1, OVF ? 32'h8000_0002 : 32'h2);
    wr(12'h323, 32'd2);
    chk("clr_ovf_vec", 64'(ovf_vec), 64'd0);
    chk("clr_ovf_irq", 64'(ovf_irq), 64'd0);
    lit("clr_evt", 12'h323, 1'b1, 32'h2);

    // Several counters, boundary event numbers, high-half truncation
    wr(12'h324, 32'd8);
    wr(12'h325, 32'd9);
    wr(12'h326, 32'd1);
    wr(12'hB84, 32'hFFFF_FF12);
    lit("evt_max", 12'h324, 1'b1, 32'd8);
    lit("evt_over", 12'h325, 1'b1, 32'd0);
    lit("hi_trunc", 12'hB84, 1'b1, 32'h12);
    foreach (PAT[p]) begin
      event_pulse = PAT[p];
      tick();
    end
    event_pulse = '0;
    lit("multi_c3", 12'hB03, 1'b1, 32'd2);
    lit("multi_c4", 12'hB04, 1'b1, 32'd4);
    lit("multi_c5", 12'hB05, 1'b1, 32'd0);
    lit("multi_c6", 12'hB06, 1'b1, 32'd3);
    lit("multi_c4hi", 12'hB84, 1'b1, 32'h12);

    // Write beats increment; bypass in the same cycle
    csr_raddr   = 12'hB03;
    csr_waddr   = 12'hB03;
    csr_wdata   = 32'h100;
    csr_wen     = 1'b1;
    event_pulse = 8'h02;
    #1;
    chk("bypass", 64'(csr_rdata), 64'h100);
    tick();
    csr_wen     = 1'b0;
    event_pulse = '0;
    lit("wr_win", 12'hB03, 1'b1, 32'h100);

    // Privilege and legalisation
    priv_level = 2'd0;
    wr(12'hB03, 32'd7);
    priv_level = 2'd3;
    lit("priv", 12'hB03, 1'b1, 32'h100);
    wr(12'h323, 32'h80);
    lit("evt_legal", 12'h323, 1'b1, 32'd0);
    lit("unimpl", 12'hB1F, 1'b1, 32'd0);
    lit("foreign", 12'h7C0, 1'b0, 32'd0);

    // Asynchronous reset while counting
    wr(12'h323, 32'd1);
    event_pulse = 8'h01;
    repeat (3) tick();
    csr_raddr = 12'hB03;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(csr_rdata), 64'd0);
    chk("arst_irq", 64'(ovf_irq), 64'd0);
    chk("arst_vec", 64'(ovf_vec), 64'd0);
    tick();
    rst_n = 1'b1;
    wr(12'h323, 32'd1);
    repeat (3) tick();
    event_pulse = '0;
    lit("restart", 12'hB03, 1'b1, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_hpm_counters.md
# csr_hpm_counters

Parametrised machine-mode hardware performance-monitor bank that extends the CSR register file with programmable event counters `mhpmcounter3..`, their event selectors `mhpmevent3..` and `mcountinhibit`. It sits beside the core CSR register file on the same CSR read/write bus. Each counter counts one of `NUM_EVENTS` single-cycle event pulses from the datapath and caches (stall, miss, branch, etc.). It wraps at a configurable width and optionally raises a sticky overflow interrupt.

## Interface
- `NUM_COUNTERS`, 4, number of implemented counters, 1..29; counter K occupies indices 3..3+NUM_COUNTERS-1
- `COUNTER_WIDTH`, 40, implemented counter bits, 33..64
- `NUM_EVENTS`, 8, width of the event input vector, 1..255
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `priv_level` in 2: privilege of the instruction issuing the CSR access
- `csr_raddr` in 12: read address
- `csr_rdata` out 32: read data, combinational
- `csr_hit` out 1: `csr_raddr` decodes to a CSR owned by this block
- `csr_wen` in 1: write strobe
- `csr_waddr` in 12: write address
- `csr_wdata` in 32: write data
- `event_pulse` in NUM_EVENTS: one-cycle event indications; bit e-1 is event number e
- `freeze` in 1: global count hold, used by the debug halt path
- `ovf_vec` out NUM_COUNTERS: per-counter overflow (OF) flags
- `ovf_irq` out 1: OR of `ovf_vec`

## Operation
- Address map (K = 3..31):
  - 0xB00+K: counter K bits [31:0]
  - 0xB80+K: counter K bits [COUNTER_WIDTH-1:32], zero-extended
  - 0x320+K: `mhpmevent`K
  - 0x320: `mcountinhibit`; bits 3..3+N-1 implemented, others read 0
- `csr_hit`=1 for any address in these ranges, including unimplemented K.
  - Unimplemented K reads 0 and ignores writes.
  - Any other address gives `csr_hit`=0 and `csr_rdata`=0.
- `mhpmevent` layout:
  - [7:0] event select. 0 means no event. A written value above `NUM_EVENTS` is stored as 0.
  - [31] OF.
  - All other bits read 0.
- Counting, per counter per cycle: increment by 1 when all of these hold:
  - the selected `event_pulse` bit is 1
  - the inhibit bit is 0
  - `freeze`=0
  - no CSR write targets this counter in the same cycle
- Wrap: all-ones +1 gives 0, and OF is set on that edge.
- Write gating: a write is ignored when `priv_level` < `csr_waddr[9:8]`. Every CSR here needs level 3.
- Write to a low half replaces bits [31:0]. Write to a high half replaces bits [COUNTER_WIDTH-1:32]; upper `csr_wdata` bits beyond the width are dropped.
- A CSR write to a counter wins over that cycle's increment. The written value is stored exactly and does not set OF.
- Read bypass: when `csr_wen` && `csr_waddr`==`csr_raddr` and the write is permitted, `csr_rdata` returns the value that will be stored. This is the masked/legalised value, not raw `csr_wdata`.
- OF is cleared only by writing `mhpmevent`K with bit31=0. A wrap in the same cycle as a clear leaves OF=1.
- Reset (`rst_n`=0, any time, asynchronous):
  - counters, selectors, `mcountinhibit` and OF go to 0
  - `ovf_vec`=0, `ovf_irq`=0
  - counting resumes on the first edge after release

## Timing
- Event pulse at edge n: counter value visible on `csr_rdata` in the cycle after edge n.
- CSR write at edge n: new value visible from cycle n+1, and in-cycle through the bypass.
- `ovf_vec`/`ovf_irq` are driven directly from registers. They assert in the cycle following the wrapping edge, with no combinational path from `event_pulse`.
- `csr_rdata`/`csr_hit` are purely combinational on the address, register state and the bypass.
- No handshake: every access completes in one cycle, and there are no stalls.

## Configuration
- `HPM_OVERFLOW_IRQ_EN` defined: OF bits, `ovf_vec` and `ovf_irq` behave as above.
- `HPM_OVERFLOW_IRQ_EN` undefined:
  - no OF storage is built
  - `mhpmevent`[31] reads 0, and writes to it are ignored
  - `ovf_vec`=0 and `ovf_irq`=0 constantly
  - counters still wrap silently

## Test plan
- Reset, then select: release reset, write `mhpmevent`3=2, pulse `event_pulse[1]` for 5 cycles. Expect 0xB03 reads 5 and 0xB83 reads 0.
- Inhibit and freeze: write `mcountinhibit`=0x8, pulse 4 times, expect the counter unchanged. Clear the inhibit, hold `freeze`=1 for 3 pulses, expect it still unchanged.
- Wrap with the macro defined, COUNTER_WIDTH=40:
  - write 0xB83=0xFF and 0xB03=0xFFFFFFFF, then 1 pulse
  - expect the counter reads 0, `ovf_vec[0]`=1 and `ovf_irq`=1 on the next cycle
  - write `mhpmevent`3=2: expect OF cleared and `ovf_irq`=0 on the next cycle
- Write vs increment: `csr_wen` to 0xB03 with 0x100 in the same cycle as a pulse. Expect the counter reads 0x100 after that edge, and 0x100 is bypassed in the same cycle.
- Privilege and legalisation:
  - at `priv_level`=0, write 0xB03=7: expect it ignored
  - write `mhpmevent`3=0x80 with NUM_EVENTS=8: expect it to read 0
  - read 0xB1F: expect `csr_hit`=1 and data 0
  - read 0x7C0: expect `csr_hit`=0
- Reset mid-count: assert `rst_n`=0 asynchronously between edges while counting. Expect every counter and `ovf_irq` to be 0 immediately, and counting to restart from 0 after release.
